// File: rtl/rom_port_arbiter_pkg.sv
// Shared constants and types for the ROM read-port arbiter.
// Requester index 0 is instruction fetch and index 1 is load/store.
package rom_port_arbiter_pkg;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam int InstrAddrBus = 32;
    localparam int InstrBus     = 32;
    localparam logic [InstrBus-1:0] ZeroWord = '0;
    localparam int RomMemNum    = 1024;

    localparam int REQ_IF = 0;
    localparam int REQ_LS = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_LS   = 2'b10
    } owner_e;

endpackage

// File: rtl/rom_port_arbiter_rr_arb2.sv
// Two-way round-robin grant generator.
// The requester that did not win the last grant wins a tie.
module rom_port_arbiter_rr_arb2
    import rom_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // 1 means LS held the most recent grant.
    logic last_ls_q;
    logic last_ls_d;

    always_comb begin
        gnt_o     = 2'b00;
        last_ls_d = last_ls_q;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_ls_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o[REQ_IF]) begin
            last_ls_d = 1'b0;
        end else if (gnt_o[REQ_LS]) begin
            last_ls_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ls_q <= 1'b1;
        end else begin
            last_ls_q <= last_ls_d;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the combinational instruction ROM port between IF and LS reads.
// Grants are combinational; responses come back registered one cycle later.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = InstrAddrBus,
    parameter int DATA_W     = InstrBus,
    parameter int ROM_DEPTH  = RomMemNum,
    parameter int ADDR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic              if_err_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic              ls_err_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_rdata_i
);

    localparam logic [ADDR_W-1:0] DepthW = ADDR_W'(ROM_DEPTH);

    logic [1:0]        gnt;
    logic              any_gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] word_idx;
    logic              in_range;

    owner_e            owner_q, owner_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] if_hold_q, ls_hold_q;

    rom_port_arbiter_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({ls_req_i, if_req_i}),
        .gnt_o (gnt)
    );

    always_comb begin
        any_gnt  = |gnt;
        sel_addr = gnt[REQ_LS] ? ls_addr_i : if_addr_i;
        word_idx = sel_addr >> ADDR_SHIFT;
        in_range = (word_idx < DepthW);

        if_gnt_o   = gnt[REQ_IF];
        ls_gnt_o   = gnt[REQ_LS];
        rom_ce_o   = (any_gnt && in_range) ? ChipEnable : ChipDisable;
        rom_addr_o = any_gnt ? word_idx : '0;

        owner_d = OWN_NONE;
        if (gnt[REQ_IF]) begin
            owner_d = OWN_IF;
        end else if (gnt[REQ_LS]) begin
            owner_d = OWN_LS;
        end
        err_d  = any_gnt && !in_range;
        data_d = (any_gnt && in_range) ? rom_rdata_i : '0;
    end

    // Flush only masks the presented IF response; the register stage is untouched.
    always_comb begin
        if_rvalid_o = (owner_q == OWN_IF) && !if_flush_i;
        ls_rvalid_o = (owner_q == OWN_LS);
        if_err_o    = if_rvalid_o && err_q;
        ls_err_o    = ls_rvalid_o && err_q;
        if_rdata_o  = if_rvalid_o ? data_q : if_hold_q;
        ls_rdata_o  = ls_rvalid_o ? data_q : ls_hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= OWN_NONE;
            err_q     <= 1'b0;
            data_q    <= '0;
            if_hold_q <= '0;
            ls_hold_q <= '0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
            data_q  <= data_d;
            if (if_rvalid_o) begin
                if_hold_q <= data_q;
            end
            if (ls_rvalid_o) begin
                ls_hold_q <= data_q;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter with a behavioural ROM and a
// response scoreboard holding one expected entry per clock cycle.
module tb_rom_port_arbiter;

    localparam logic [1:0] O_NONE = 2'd0;
    localparam logic [1:0] O_IF   = 2'd1;
    localparam logic [1:0] O_LS   = 2'd2;

    typedef struct packed {
        logic [1:0]  own;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        if_req, if_flush, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_gnt, ls_rvalid, ls_err;
    logic [31:0] ls_addr, ls_rdata;
    logic        rom_ce;
    logic [31:0] rom_addr, rom_rdata;

    logic [31:0] rom_mem [0:1023];

    int pass_cnt  = 0;
    int total_cnt = 0;

    resp_t exp_q[$];
    logic  last_ls_m;
    logic  e_if_g, e_ls_g, e_ce, e_if_v, e_if_e, e_ls_v, e_ls_e;
    logic [31:0] e_addr, m_if_rdata, m_ls_rdata;

    rom_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_flush_i  (if_flush),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_err_o    (if_err),
        .if_rdata_o  (if_rdata),
        .ls_req_i    (ls_req),
        .ls_addr_i   (ls_addr),
        .ls_gnt_o    (ls_gnt),
        .ls_rvalid_o (ls_rvalid),
        .ls_err_o    (ls_err),
        .ls_rdata_o  (ls_rdata),
        .rom_ce_o    (rom_ce),
        .rom_addr_o  (rom_addr),
        .rom_rdata_i (rom_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Garbage when disabled so an out-of-range read cannot leak ROM data.
    assign rom_rdata = rom_ce ? rom_mem[rom_addr[9:0]] : 32'hDEAD_BEEF;

    task automatic model_reset();
        last_ls_m  = 1'b1;
        m_if_rdata = '0;
        m_ls_rdata = '0;
        exp_q.delete();
        exp_q.push_back('{own: O_NONE, err: 1'b0, data: 32'h0});
    endtask

    // Drives one cycle of inputs and computes the expected outputs for it.
    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic lr, input logic [31:0] la, input logic fl);
        resp_t       r;
        logic [31:0] idx;
        logic        g;
        if_req = ir; if_addr = ia; ls_req = lr; ls_addr = la; if_flush = fl;
        #1;
        e_if_g = ir && (!lr || last_ls_m);
        e_ls_g = lr && !e_if_g;
        g      = e_if_g || e_ls_g;
        idx    = (e_if_g ? ia : la) >> 2;
        e_addr = g ? idx : 32'h0;
        e_ce   = g && (idx < 32'd1024);
        r      = (exp_q.size() > 0) ? exp_q.pop_front() : '{own: O_NONE, err: 1'b0, data: 32'h0};
        e_if_v = (r.own == O_IF) && !fl;
        e_ls_v = (r.own == O_LS);
        e_if_e = e_if_v && r.err;
        e_ls_e = e_ls_v && r.err;
        if (e_if_v) m_if_rdata = r.data;
        if (e_ls_v) m_ls_rdata = r.data;
        exp_q.push_back('{own:  e_if_g ? O_IF : (e_ls_g ? O_LS : O_NONE),
                          err:  g && !e_ce,
                          data: e_ce ? rom_mem[idx[9:0]] : 32'h0});
        if (g) last_ls_m = e_ls_g;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 0; if_addr = 0; ls_req = 0; ls_addr = 0; if_flush = 0;
        model_reset();
        #3;
        total_cnt++;
        if ({if_rvalid, if_err, ls_rvalid, ls_err, if_rdata, ls_rdata, rom_ce, rom_addr} !== '0)
            $display("FAIL reset_outputs: got rv/err %b%b%b%b rdata %h %h ce %b addr %h, want all zero",
                     if_rvalid, if_err, ls_rvalid, ls_err, if_rdata, ls_rdata, rom_ce, rom_addr);
        else pass_cnt++;
        #7 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_if_only();
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, (i < 3) ? addrs[i] : 32'h0, 1'b0, 32'h0, 1'b0);
            total_cnt++;
            if ({if_gnt, ls_gnt, rom_ce, rom_addr} !== {e_if_g, e_ls_g, e_ce, e_addr})
                $display("FAIL if_only_grant[%0d]: got g %b%b ce %b addr %h, want g %b%b ce %b addr %h",
                         i, if_gnt, ls_gnt, rom_ce, rom_addr, e_if_g, e_ls_g, e_ce, e_addr);
            else pass_cnt++;
            total_cnt++;
            if ({if_rvalid, if_err, ls_rvalid, ls_err, if_rdata, ls_rdata} !==
                {e_if_v, e_if_e, e_ls_v, e_ls_e, m_if_rdata, m_ls_rdata})
                $display("FAIL if_only_resp[%0d]: got rv %b ls_rv %b rdata %h, want rv %b ls_rv %b rdata %h",
                         i, if_rvalid, ls_rvalid, if_rdata, e_if_v, e_ls_v, m_if_rdata);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (if_rdata !== 32'h33)
            $display("FAIL if_only_last_word: got %h, want 00000033", if_rdata);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h0, 1'b1, 32'h10, 1'b0);
            total_cnt++;
            if ({if_gnt, ls_gnt, rom_ce, rom_addr} !== {e_if_g, e_ls_g, e_ce, e_addr})
                $display("FAIL rr_grant[%0d]: got g %b%b ce %b addr %h, want g %b%b ce %b addr %h",
                         i, if_gnt, ls_gnt, rom_ce, rom_addr, e_if_g, e_ls_g, e_ce, e_addr);
            else pass_cnt++;
            total_cnt++;
            if ({if_rvalid, if_err, ls_rvalid, ls_err, if_rdata, ls_rdata} !==
                {e_if_v, e_if_e, e_ls_v, e_ls_e, m_if_rdata, m_ls_rdata})
                $display("FAIL rr_resp[%0d]: got rv %b%b rdata %h %h, want rv %b%b rdata %h %h",
                         i, if_rvalid, ls_rvalid, if_rdata, ls_rdata, e_if_v, e_ls_v, m_if_rdata, m_ls_rdata);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_out_of_range();
        // Boundary: last valid word, first invalid word, then a far-out IF address.
        logic        lr [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] la [4] = '{32'hFFC, 32'h1000, 32'h0, 32'h0};
        logic        ir [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ia [4] = '{32'h0, 32'h0, 32'h8000_0000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            drive(ir[i], ia[i], lr[i], la[i], 1'b0);
            total_cnt++;
            if ({if_gnt, ls_gnt, rom_ce, rom_addr} !== {e_if_g, e_ls_g, e_ce, e_addr})
                $display("FAIL oor_grant[%0d]: got g %b%b ce %b addr %h, want g %b%b ce %b addr %h",
                         i, if_gnt, ls_gnt, rom_ce, rom_addr, e_if_g, e_ls_g, e_ce, e_addr);
            else pass_cnt++;
            total_cnt++;
            if ({if_rvalid, if_err, ls_rvalid, ls_err, if_rdata, ls_rdata} !==
                {e_if_v, e_if_e, e_ls_v, e_ls_e, m_if_rdata, m_ls_rdata})
                $display("FAIL oor_resp[%0d]: got rv/err %b%b%b%b rdata %h %h, want %b%b%b%b rdata %h %h",
                         i, if_rvalid, if_err, ls_rvalid, ls_err, if_rdata, ls_rdata,
                         e_if_v, e_if_e, e_ls_v, e_ls_e, m_if_rdata, m_ls_rdata);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        // Flush in a grant cycle is harmless; flush in a response cycle hides it.
        logic        ir [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] ia [5] = '{32'h4, 32'h0, 32'h8, 32'h40, 32'h0};
        logic        fl [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(ir[i], ia[i], 1'b0, 32'h0, fl[i]);
            total_cnt++;
            if ({if_gnt, ls_gnt, rom_ce, rom_addr} !== {e_if_g, e_ls_g, e_ce, e_addr})
                $display("FAIL flush_grant[%0d]: got g %b%b ce %b addr %h, want g %b%b ce %b addr %h",
                         i, if_gnt, ls_gnt, rom_ce, rom_addr, e_if_g, e_ls_g, e_ce, e_addr);
            else pass_cnt++;
            total_cnt++;
            if ({if_rvalid, if_err, ls_rvalid, ls_err, if_rdata, ls_rdata} !==
                {e_if_v, e_if_e, e_ls_v, e_ls_e, m_if_rdata, m_ls_rdata})
                $display("FAIL flush_resp[%0d]: got rv %b rdata %h, want rv %b rdata %h",
                         i, if_rvalid, if_rdata, e_if_v, m_if_rdata);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (if_rdata !== rom_mem[16])
            $display("FAIL flush_word16: got %h, want %h", if_rdata, rom_mem[16]);
        else pass_cnt++;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            total_cnt++;
            if ({if_gnt, ls_gnt, rom_ce, rom_addr, if_rvalid, ls_rvalid} !==
                {e_if_g, e_ls_g, e_ce, e_addr, e_if_v, e_ls_v})
                $display("FAIL idle[%0d]: got g %b%b ce %b addr %h rv %b%b, want g %b%b ce %b addr %h rv %b%b",
                         i, if_gnt, ls_gnt, rom_ce, rom_addr, if_rvalid, ls_rvalid,
                         e_if_g, e_ls_g, e_ce, e_addr, e_if_v, e_ls_v);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        // Last grant before idling went to IF, so LS must win this tie.
        drive(1'b1, 32'h0, 1'b1, 32'h10, 1'b0);
        total_cnt++;
        if ({if_gnt, ls_gnt} !== {e_if_g, e_ls_g} || ls_gnt !== 1'b1)
            $display("FAIL idle_tie: got g %b%b, want g %b%b", if_gnt, ls_gnt, e_if_g, e_ls_g);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 32'h0, 1'b1, 32'h14, 1'b0);
        total_cnt++;
        if ({ls_gnt, rom_ce, rom_addr} !== {e_ls_g, e_ce, e_addr})
            $display("FAIL midrst_grant: got g %b ce %b addr %h, want g %b ce %b addr %h",
                     ls_gnt, rom_ce, rom_addr, e_ls_g, e_ce, e_addr);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({if_rvalid, if_err, ls_rvalid, ls_err, if_rdata, ls_rdata} !== '0)
            $display("FAIL midrst_outputs: got rv/err %b%b%b%b rdata %h %h, want all zero",
                     if_rvalid, if_err, ls_rvalid, ls_err, if_rdata, ls_rdata);
        else pass_cnt++;
        ls_req = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 32'h0, 1'b1, 32'h10, 1'b0);
        total_cnt++;
        if ({if_rvalid, ls_rvalid} !== {e_if_v, e_ls_v})
            $display("FAIL midrst_no_rvalid: got rv %b%b, want %b%b", if_rvalid, ls_rvalid, e_if_v, e_ls_v);
        else pass_cnt++;
        total_cnt++;
        if ({if_gnt, ls_gnt} !== {e_if_g, e_ls_g} || if_gnt !== 1'b1)
            $display("FAIL midrst_first_tie: got g %b%b, want g %b%b", if_gnt, ls_gnt, e_if_g, e_ls_g);
        else pass_cnt++;
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        total_cnt++;
        if ({if_rvalid, if_rdata, ls_rvalid} !== {e_if_v, m_if_rdata, e_ls_v})
            $display("FAIL midrst_resp: got rv %b rdata %h ls_rv %b, want rv %b rdata %h ls_rv %b",
                     if_rvalid, if_rdata, ls_rvalid, e_if_v, m_if_rdata, e_ls_v);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = 32'hA500_0000 | i;
        rom_mem[0] = 32'h11;
        rom_mem[1] = 32'h22;
        rom_mem[2] = 32'h33;

        test_reset();
        test_if_only();
        test_round_robin();
        test_out_of_range();
        test_flush();
        test_idle();
        test_reset_mid();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational instruction-ROM read port between two requesters: instruction fetch (IF) and load/store (LS) reads of constant data held in ROM.
- Arbitrates requests round-robin and drives the ROM chip-enable and word address.
- Registers the ROM data and returns it one cycle after grant, with per-requester valid and error flags.
- Sits between the fetch/LSU stages and the ROM instance in the core top level.

Parameters:
- ADDR_W, 32, requester byte-address width.
- DATA_W, 32, ROM word width.
- ROM_DEPTH, 1024, number of ROM words.
- ADDR_SHIFT, 2, right shift converting byte address to ROM word index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req_i  in  1  IF read request, held until granted.
- if_addr_i  in  ADDR_W  IF byte address.
- if_flush_i  in  1  discard IF response due next cycle (branch/jump).
- if_gnt_o  out  1  IF request accepted this cycle.
- if_rvalid_o  out  1  IF response valid.
- if_err_o  out  1  IF response is out-of-range.
- if_rdata_o  out  DATA_W  IF response data.
- ls_req_i  in  1  LS read request, held until granted.
- ls_addr_i  in  ADDR_W  LS byte address.
- ls_gnt_o  out  1  LS request accepted.
- ls_rvalid_o  out  1  LS response valid.
- ls_err_o  out  1  LS response is out-of-range.
- ls_rdata_o  out  DATA_W  LS response data.
- rom_ce_o  out  1  ROM chip enable.
- rom_addr_o  out  ADDR_W  ROM word index.
- rom_rdata_i  in  DATA_W  ROM data, combinational from rom_addr_o.

Behaviour:
- Reset (asynchronous, active-high): all rvalid and err outputs 0, rdata outputs 0, last_grant = LS (so IF wins the first tie), response owner = NONE.
- Grant (combinational, same cycle):
  - Exactly one requester: it is granted.
  - Both requesting: the one not in last_grant is granted.
  - Neither: no grant, rom_ce_o = 0, rom_addr_o = 0.
- ROM drive:
  - rom_ce_o = 1 only when a grant is issued and the address is in range.
  - rom_addr_o = granted address >> ADDR_SHIFT.
- Range check: word index ≥ ROM_DEPTH means out of range.
  - Still granted, but ROM is not enabled.
  - Response carries err = 1 and data = 0.
- Response latency is exactly 1 cycle after grant.
  - At the grant edge, register owner, err flag and data (rom_rdata_i, or 0 on error).
  - Next cycle, the owner's rvalid = 1 and the other requester's rvalid = 0.
  - rdata outputs hold their last value when rvalid = 0.
- Back-to-back: a new grant may be issued in the same cycle a response is presented. Full throughput is one read per cycle.
- last_grant updates only on a cycle with a grant.
- if_flush_i:
  - Asserted in the cycle an IF response is presented: that response is suppressed (rvalid forced 0), and any IF grant in the same cycle is still honoured.
  - Asserted in the grant cycle: has no effect on that grant.
- Simultaneous requests with the same address: served sequentially, with no merging.
- A request withdrawn before grant is legal and is ignored.
- Reset mid-operation: any pending response is dropped and no rvalid follows.
- State held:
  - last_grant (1 bit).
  - Response stage: owner NONE/IF/LS, err, data.

Decomposition:
- Shared defines file: ChipEnable/ChipDisable, ZeroWord, InstrAddrBus/InstrBus widths, RomMemNum (default for ROM_DEPTH), and an owner encoding (OWN_NONE=2'b00, OWN_IF=2'b01, OWN_LS=2'b10).
- One natural sub-module: rr_arb2, a 2-way round-robin grant generator holding last_grant.

Test Plan:
- Reset, then IF-only reads at 0x0, 0x4, 0x8 with ROM words 0x11, 0x22, 0x33 → if_gnt_o every cycle, rom_addr_o = 0, 1, 2, if_rvalid_o with 0x11, 0x22, 0x33 one cycle later each; ls_rvalid_o stays 0.
- Both requesting continuously (IF 0x0, LS 0x10) → grants alternate IF, LS, IF, LS; responses alternate owner one cycle later with ROM words 0 and 4.
- LS read at 0x1000 (index 1024) → ls_gnt_o = 1, rom_ce_o = 0; next cycle ls_rvalid_o = 1, ls_err_o = 1, ls_rdata_o = 0.
- IF granted at 0x8; next cycle if_flush_i = 1 with a new IF request at 0x40 → no rvalid for 0x8; the 0x40 response (ROM word 16) appears the following cycle.
- Assert rst asynchronously between an LS grant and its response → ls_rvalid_o never asserts, outputs zero immediately; after release, IF wins the first tie.
- No requests for 5 cycles → rom_ce_o = 0, rom_addr_o = 0, both rvalid = 0, last_grant unchanged.
